// File: rtl/trace_pkg.sv
// Shared constants and types for the TPIU trace frame builder.
package trace_pkg;

    localparam int unsigned FRAME_WORDS_LOG2_DEF  = 3;
    localparam int unsigned SYNC_TIMEOUT_LOG2_DEF = 16;

    localparam logic [15:0] TPIU_FSYNC_HI = 16'hFFFF;
    localparam logic [15:0] TPIU_HSYNC    = 16'h7FFF;

    // Full sync as it arrives on the wire: FF,FF,FF,7F, oldest byte in the MSBs.
    localparam logic [31:0] FSYNC_BYTES   = 32'hFFFF_FF7F;

    typedef enum logic {
        UNSYNC = 1'b0,
        SYNCED = 1'b1
    } state_e;

endpackage

// File: rtl/trace_frame_builder_if.sv
// Byte-in / word-out bus between the TPIU deserialiser, frame builder and send buffer.
interface trace_frame_builder_if;
    import trace_pkg::*;

    logic [7:0]  ByteIn;
    logic        ByteAvail;
    logic [15:0] PacketWd;
    logic        WdAvail;
    logic        PacketReset;
    logic        sync;
    logic        FrameDone;

    modport master (
        output ByteIn, ByteAvail,
        input  PacketWd, WdAvail, PacketReset, sync, FrameDone
    );

    modport slave (
        input  ByteIn, ByteAvail,
        output PacketWd, WdAvail, PacketReset, sync, FrameDone
    );

endinterface

// File: rtl/tpiu_sync_detect.sv
// Byte-stream full-sync detector: flags the byte that completes FF,FF,FF,7F.
module tpiu_sync_detect
    import trace_pkg::*;
(
    input  logic       wrClk,
    input  logic       rst,
    input  logic [7:0] byte_i,
    input  logic       en_i,
    input  logic       clr_i,
    output logic       found_c
);

    // Three stored bytes plus the incoming one form the 32-bit comparison window.
    logic [23:0] hist_q, hist_d;
    logic [31:0] window;

    assign window = {hist_q, byte_i};

    always_comb begin
        hist_d = hist_q;
        if (clr_i) begin
            hist_d = '0;
        end else if (en_i) begin
            hist_d = window[23:0];
        end
    end

    always_ff @(posedge wrClk) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign found_c = en_i && (window == FSYNC_BYTES);

endmodule

// File: rtl/trace_frame_builder.sv
// Aligns the TPIU byte stream, strips syncs and emits framed 16-bit words to the send buffer.
module trace_frame_builder
    import trace_pkg::*;
#(
    parameter int unsigned SYNC_TIMEOUT_LOG2 = SYNC_TIMEOUT_LOG2_DEF,
    parameter int unsigned FRAME_WORDS_LOG2  = FRAME_WORDS_LOG2_DEF
) (
    input  logic                 wrClk,
    input  logic                 rst,
    trace_frame_builder_if.slave bus
);

    localparam int unsigned TW = SYNC_TIMEOUT_LOG2;
    localparam int unsigned FW = FRAME_WORDS_LOG2;
    // Last count before the maximum; the byte arriving here hits the timeout.
    localparam logic [TW-1:0] TO_LAST = {{(TW-1){1'b1}}, 1'b0};

    state_e        state_q, state_d;
    logic          byte_sel_q, byte_sel_d;
    logic [7:0]    low_q, low_d;
    logic          pend_q, pend_d;
    logic [15:0]   held_q, held_d;
    logic          held_vld_q, held_vld_d;
    logic [FW-1:0] word_cnt_q, word_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [15:0]   pkt_wd_q, pkt_wd_d;
    logic          wd_avail_q, wd_avail_d;
    logic          pkt_rst_q, pkt_rst_d;
    logic          frame_done_q, frame_done_d;

    logic [15:0]   word_c;
    logic [15:0]   emit_wd_c;
    logic          emit_c, fsync_c, timeout_c;
    logic          sr_en_c, sr_clr_c, found_c;

    tpiu_sync_detect u_sync_detect (
        .wrClk   (wrClk),
        .rst     (rst),
        .byte_i  (bus.ByteIn),
        .en_i    (sr_en_c),
        .clr_i   (sr_clr_c),
        .found_c (found_c)
    );

    always_ff @(posedge wrClk) begin
        if (rst) begin
            state_q      <= UNSYNC;
            byte_sel_q   <= 1'b0;
            low_q        <= '0;
            pend_q       <= 1'b0;
            held_q       <= '0;
            held_vld_q   <= 1'b0;
            word_cnt_q   <= '0;
            to_cnt_q     <= '0;
            pkt_wd_q     <= '0;
            wd_avail_q   <= 1'b0;
            pkt_rst_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_sel_q   <= byte_sel_d;
            low_q        <= low_d;
            pend_q       <= pend_d;
            held_q       <= held_d;
            held_vld_q   <= held_vld_d;
            word_cnt_q   <= word_cnt_d;
            to_cnt_q     <= to_cnt_d;
            pkt_wd_q     <= pkt_wd_d;
            wd_avail_q   <= wd_avail_d;
            pkt_rst_q    <= pkt_rst_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Word filter: pairing, FFFF hold-back, sync stripping, timeout and framing.
    always_comb begin
        state_d      = state_q;
        byte_sel_d   = byte_sel_q;
        low_d        = low_q;
        pend_d       = pend_q;
        held_d       = held_q;
        held_vld_d   = held_vld_q;
        word_cnt_d   = word_cnt_q;
        to_cnt_d     = to_cnt_q;
        pkt_wd_d     = pkt_wd_q;
        wd_avail_d   = 1'b0;
        pkt_rst_d    = 1'b0;
        frame_done_d = 1'b0;
        word_c       = {bus.ByteIn, low_q};
        emit_c       = 1'b0;
        emit_wd_c    = '0;
        fsync_c      = 1'b0;
        timeout_c    = 1'b0;
        sr_en_c      = 1'b0;
        sr_clr_c     = 1'b0;

        case (state_q)
            UNSYNC: begin
                sr_en_c = bus.ByteAvail;
                if (found_c) begin
                    state_d    = SYNCED;
                    byte_sel_d = 1'b0;
                    word_cnt_d = '0;
                    pend_d     = 1'b0;
                    to_cnt_d   = '0;
                end
            end
            SYNCED: begin
                if (held_vld_q) begin
                    emit_c     = 1'b1;
                    emit_wd_c  = held_q;
                    held_vld_d = 1'b0;
                end
                if (bus.ByteAvail) begin
                    to_cnt_d   = to_cnt_q + TW'(1);
                    byte_sel_d = ~byte_sel_q;
                    if (!byte_sel_q) begin
                        low_d = bus.ByteIn;
                    end else if (pend_q) begin
                        if (word_c == TPIU_HSYNC) begin
                            fsync_c  = 1'b1;
                            pend_d   = 1'b0;
                            to_cnt_d = '0;
                        end else begin
                            emit_c    = 1'b1;
                            emit_wd_c = TPIU_FSYNC_HI;
                            if (word_c != TPIU_FSYNC_HI) begin
                                pend_d     = 1'b0;
                                held_d     = word_c;
                                held_vld_d = 1'b1;
                            end
                        end
                    end else if (word_c == TPIU_FSYNC_HI) begin
                        pend_d = 1'b1;
                    end else if (word_c != TPIU_HSYNC) begin
                        emit_c    = 1'b1;
                        emit_wd_c = word_c;
                    end
                    timeout_c = !fsync_c && (to_cnt_q == TO_LAST);
                end
                if (fsync_c && (word_cnt_q != '0)) begin
                    pkt_rst_d  = 1'b1;
                    word_cnt_d = '0;
                end
                // Losing alignment discards the partial frame and any word in flight.
                if (timeout_c) begin
                    state_d    = UNSYNC;
                    pend_d     = 1'b0;
                    held_d     = '0;
                    held_vld_d = 1'b0;
                    byte_sel_d = 1'b0;
                    to_cnt_d   = '0;
                    sr_clr_c   = 1'b1;
                    emit_c     = 1'b0;
                    pkt_rst_d  = (word_cnt_q != '0);
                    word_cnt_d = '0;
                end
                if (emit_c) begin
                    wd_avail_d   = 1'b1;
                    pkt_wd_d     = emit_wd_c;
                    word_cnt_d   = word_cnt_q + FW'(1);
                    frame_done_d = (word_cnt_q == '1);
                end
            end
            default: state_d = UNSYNC;
        endcase
    end

    assign bus.PacketWd    = pkt_wd_q;
    assign bus.WdAvail     = wd_avail_q;
    assign bus.PacketReset = pkt_rst_q;
    assign bus.FrameDone   = frame_done_q;
    assign bus.sync        = (state_q == SYNCED);

endmodule

// File: tb/tb_trace_frame_builder.sv
// Directed and randomized bench for trace_frame_builder, scored against an event-level model.
module tb_trace_frame_builder;
    import trace_pkg::*;

    localparam int FWORDS = 8;
    localparam logic [31:0] EV_WORD = 32'h0001_0000;
    localparam logic [31:0] EV_FD   = 32'h0010_0000;
    localparam logic [31:0] EV_PR   = 32'h0002_0000;
    localparam logic [31:0] EV_UP   = 32'h0003_0000;
    localparam logic [31:0] EV_DOWN = 32'h0004_0000;

    // FFFF / halfword handling stimulus and per-byte expected {WdAvail, PacketWd}.
    localparam logic [7:0]  HB [12] = '{8'hFF, 8'hFF, 8'hAA, 8'hAA, 8'hFF, 8'h7F,
                                        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
    localparam logic [16:0] HE [12] = '{17'h0, 17'h0, 17'h0, 17'h1FFFF, 17'h1AAAA, 17'h0,
                                        17'h0, 17'h0, 17'h0, 17'h1FFFF, 17'h0, 17'h0};

    logic wrClk = 1'b0;
    logic rst;
    always #5 wrClk = ~wrClk;

    trace_frame_builder_if bus_a ();
    trace_frame_builder_if bus_b ();

    trace_frame_builder #(.SYNC_TIMEOUT_LOG2(16), .FRAME_WORDS_LOG2(3)) dut_a (
        .wrClk (wrClk), .rst (rst), .bus (bus_a)
    );
    trace_frame_builder #(.SYNC_TIMEOUT_LOG2(4), .FRAME_WORDS_LOG2(3)) dut_b (
        .wrClk (wrClk), .rst (rst), .bus (bus_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, one slot per DUT.
    bit          m_synced [2];
    bit          m_have_low [2];
    bit          m_pend [2];
    bit          m_held_v [2];
    logic [15:0] m_held [2];
    logic [7:0]  m_low [2];
    logic [31:0] m_win [2];
    int          m_since [2];
    int          m_fc [2];
    int          m_tmax [2] = '{65535, 15};
    logic [31:0] exp_q [2][$];

    // Observation trackers for directed checks.
    bit          prev_sync [2];
    int          wd_n [2];
    int          pr_n [2];
    int          fd_n [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset(input int k);
        m_synced[k] = 0; m_have_low[k] = 0; m_pend[k] = 0; m_held_v[k] = 0;
        m_held[k] = '0; m_low[k] = '0; m_win[k] = '0; m_since[k] = 0; m_fc[k] = 0;
        exp_q[k].delete();
    endfunction

    function automatic void m_emit(input int k, input logic [15:0] w);
        exp_q[k].push_back(EV_WORD | ((m_fc[k] == FWORDS - 1) ? EV_FD : 32'h0) | 32'(w));
        m_fc[k] = (m_fc[k] + 1) % FWORDS;
    endfunction

    function automatic void m_step(input int k, input bit av, input logic [7:0] b);
        bit fs = 0, tmo = 0, have_em = 0, held_prev;
        logic [15:0] em = '0, w;
        held_prev = m_held_v[k];
        m_held_v[k] = 0;
        if (!m_synced[k]) begin
            if (av) begin
                m_win[k] = {m_win[k][23:0], b};
                if (m_win[k] == 32'hFFFF_FF7F) begin
                    m_synced[k] = 1; m_have_low[k] = 0; m_pend[k] = 0;
                    m_since[k] = 0; m_fc[k] = 0;
                    exp_q[k].push_back(EV_UP);
                end
            end
            return;
        end
        if (av) begin
            m_since[k]++;
            if (!m_have_low[k]) begin
                m_low[k] = b; m_have_low[k] = 1;
            end else begin
                m_have_low[k] = 0;
                w = {b, m_low[k]};
                if (m_pend[k]) begin
                    if (w == 16'h7FFF) begin
                        fs = 1; m_pend[k] = 0;
                    end else begin
                        have_em = 1; em = 16'hFFFF;
                        if (w != 16'hFFFF) begin
                            m_pend[k] = 0; m_held[k] = w; m_held_v[k] = 1;
                        end
                    end
                end else if (w == 16'hFFFF) begin
                    m_pend[k] = 1;
                end else if (w != 16'h7FFF) begin
                    have_em = 1; em = w;
                end
            end
            if (fs) m_since[k] = 0;
            else tmo = (m_since[k] == m_tmax[k]);
        end
        if (held_prev && !tmo) m_emit(k, m_held[k]);
        if (fs && m_fc[k] != 0) begin
            exp_q[k].push_back(EV_PR); m_fc[k] = 0;
        end
        if (tmo) begin
            if (m_fc[k] != 0) exp_q[k].push_back(EV_PR);
            m_fc[k] = 0; m_synced[k] = 0; m_pend[k] = 0; m_held_v[k] = 0;
            m_have_low[k] = 0; m_win[k] = '0;
            exp_q[k].push_back(EV_DOWN);
        end else if (have_em) begin
            m_emit(k, em);
        end
    endfunction

    task automatic match_ev(input int k, input logic [31:0] obs);
        if (exp_q[k].size() == 0) check($sformatf("evt%0d", k), obs, 32'hFFFF_FFFF);
        else check($sformatf("evt%0d", k), obs, exp_q[k].pop_front());
    endtask

    task automatic observe(input int k, input logic wd, input logic [15:0] pw, input logic pr,
                           input logic sy, input logic fd, input bit r);
        if (r) begin
            check($sformatf("rst_out%0d", k), 32'({wd, pr, sy, fd, pw}), 32'h0);
            prev_sync[k] = 0;
            return;
        end
        check($sformatf("excl%0d", k), 32'(wd & pr), 32'h0);
        if (wd) begin
            wd_n[k]++;
            if (fd) fd_n[k]++;
            match_ev(k, EV_WORD | (fd ? EV_FD : 32'h0) | 32'(pw));
        end else begin
            check($sformatf("fd_alone%0d", k), 32'(fd), 32'h0);
        end
        if (pr) begin
            pr_n[k]++;
            match_ev(k, EV_PR);
        end
        if (sy !== prev_sync[k]) begin
            match_ev(k, sy ? EV_UP : EV_DOWN);
            prev_sync[k] = sy;
        end
        check($sformatf("lag%0d", k), 32'(exp_q[k].size()), 32'h0);
    endtask

    task automatic cyc(input bit av, input logic [7:0] b, input bit r);
        rst = r;
        bus_a.ByteAvail = av; bus_a.ByteIn = b;
        bus_b.ByteAvail = av; bus_b.ByteIn = b;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                check($sformatf("q_at_rst%0d", k), 32'(exp_q[k].size()), 32'h0);
                m_reset(k);
            end else begin
                m_step(k, av, b);
            end
        end
        @(posedge wrClk);
        @(negedge wrClk);
        observe(0, bus_a.WdAvail, bus_a.PacketWd, bus_a.PacketReset, bus_a.sync, bus_a.FrameDone, r);
        observe(1, bus_b.WdAvail, bus_b.PacketWd, bus_b.PacketReset, bus_b.sync, bus_b.FrameDone, r);
    endtask

    task automatic feed(input logic [7:0] b);
        cyc(1'b1, b, 1'b0);
    endtask

    task automatic do_sync();
        feed(8'hFF); feed(8'hFF); feed(8'hFF); feed(8'h7F);
    endtask

    task automatic clr_track();
        for (int k = 0; k < 2; k++) begin
            wd_n[k] = 0; pr_n[k] = 0; fd_n[k] = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wd_before;
        logic [7:0] rb;
        m_reset(0); m_reset(1);
        clr_track();

        // Reset state
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        check("rst_sync", 32'(bus_a.sync), 32'h0);

        // Sync acquisition and first words
        feed(8'h12); feed(8'hFF); feed(8'hFF); feed(8'hFF);
        check("presync", 32'(bus_a.sync), 32'h0);
        feed(8'h7F);
        check("sync_up", 32'(bus_a.sync), 32'h1);
        feed(8'h01);
        check("lat_first_byte", 32'(bus_a.WdAvail), 32'h0);
        feed(8'h02);
        check("w0201", 32'({bus_a.WdAvail, bus_a.PacketWd}), 32'h1_0201);
        feed(8'h03); feed(8'h04);
        check("w0403", 32'({bus_a.WdAvail, bus_a.PacketWd}), 32'h1_0403);

        // Full frame
        cyc(1'b0, 8'h00, 1'b1);
        do_sync();
        clr_track();
        for (int i = 0; i < 16; i++) begin
            feed(8'(i));
            if (i % 2 == 1) begin
                check("frame_wd", 32'({bus_a.WdAvail, bus_a.PacketWd}),
                      32'({1'b1, 8'(i), 8'(i - 1)}));
                check("frame_fd", 32'(bus_a.FrameDone), 32'(i == 15));
            end
        end
        check("frame_count", 32'(wd_n[0]), 32'd8);

        // FFFF hold-back and halfword sync stripping
        clr_track();
        for (int i = 0; i < 12; i++) begin
            feed(HB[i]);
            check("hw_wdavail", 32'(bus_a.WdAvail), 32'(HE[i][16]));
            if (HE[i][16]) check("hw_word", 32'(bus_a.PacketWd), 32'(HE[i][15:0]));
        end
        check("hw_preset", 32'(pr_n[0]), 32'd1);
        check("hw_count", 32'(wd_n[0]), 32'd3);

        // Mid-frame resync
        feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44); feed(8'h55); feed(8'h66);
        clr_track();
        do_sync();
        check("resync_pr", 32'({bus_a.PacketReset, bus_a.WdAvail}), 32'h2);
        for (int i = 0; i < 16; i++) feed(8'(8'h20 + i));
        check("resync_fd_last", 32'(bus_a.FrameDone), 32'h1);
        check("resync_fd_n", 32'(fd_n[0]), 32'd1);

        // Timeout on the short-timeout instance
        cyc(1'b0, 8'h00, 1'b1);
        do_sync();
        for (int i = 0; i < 14; i++) feed(8'(8'h10 + i));
        check("to_still_sync", 32'(bus_b.sync), 32'h1);
        clr_track();
        feed(8'h40);
        check("to_sync_drop", 32'({bus_b.sync, bus_b.PacketReset}), 32'h1);
        check("to_long_sync", 32'(bus_a.sync), 32'h1);
        for (int i = 0; i < 4; i++) feed(8'(8'h50 + i));
        check("to_no_words", 32'(wd_n[1]), 32'd0);
        check("to_pr_once", 32'(pr_n[1]), 32'd1);

        // Reset while a word is held
        cyc(1'b0, 8'h00, 1'b1);
        do_sync();
        feed(8'hFF); feed(8'hFF); feed(8'h12); feed(8'h34);
        check("held_ffff", 32'({bus_a.WdAvail, bus_a.PacketWd}), 32'h1_FFFF);
        cyc(1'b0, 8'h00, 1'b1);
        check("held_rst_out", 32'({bus_a.WdAvail, bus_a.PacketReset, bus_a.sync}), 32'h0);
        wd_before = wd_n[0];
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);
        check("held_dropped", 32'(wd_n[0]), 32'(wd_before));

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 999) == 0) begin
                cyc(1'b0, 8'h00, 1'b1);
            end else if ($urandom_range(0, 79) == 0) begin
                do_sync();
            end else begin
                case ($urandom_range(0, 9))
                    0, 1, 2: rb = 8'hFF;
                    3:       rb = 8'h7F;
                    default: rb = 8'($urandom);
                endcase
                cyc($urandom_range(0, 3) != 0, rb, 1'b0);
            end
        end

        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);
        check("q_empty_a", 32'(exp_q[0].size()), 32'h0);
        check("q_empty_b", 32'(exp_q[1].size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
